// File: rtl/dbg_bridge_cmd_parser.sv
// dbg_bridge_cmd_parser
// Decodes write/read command frames from the UART byte stream into
// 32-bit word requests for the bus-master stage.
// Frame: CMD, LEN(1..255), ADDR[31:24..7:0], then LEN data bytes for writes.
//
// Ports:
//   clk_i, rst_i          clock, asynchronous active-low reset
//   rx_valid_i/rx_data_i  received byte stream; rx_ready_o accepts a byte
//   req_*_o/req_ready_i   one word request per bus beat (valid/ready)
//   err_o                 one-cycle pulse on bad command, LEN=0 or timeout
//   busy_o                parser is mid-frame
//
// Optional feature: define DBG_BRIDGE_CMD_TIMEOUT_EN to abort a frame after
// TIMEOUT_CYCLES idle cycles between bytes.
module dbg_bridge_cmd_parser #(
    parameter int unsigned ADDR_W         = 32,
    parameter logic [7:0]  CMD_WR         = 8'h10,
    parameter logic [7:0]  CMD_RD         = 8'h11,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_write_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [31:0]       req_wdata_o,
    output logic [3:0]        req_wstrb_o,
    output logic              req_last_o,
    output logic              err_o,
    output logic              busy_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned LEN_W  = 8;
    localparam int unsigned CNT_W  = 2;

    // Parameter sanity: the address shifter needs at least 9 bits.
    if (ADDR_W < 9) begin : g_bad_addr_w
        $error("ADDR_W must be at least 9");
    end
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_ADDR  = 3'd2,
        S_DATA  = 3'd3,
        S_ISSUE = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [LEN_W-1:0]    rem_q, rem_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                is_wr_q, is_wr_d;
    logic                last_q, last_d;
    logic                err_q, err_d;
    logic                rx_ready_q, rx_ready_d;
    logic                busy_q, busy_d;
    logic                req_valid_q, req_valid_d;

    logic                byte_acc_c;
    logic                req_acc_c;
    logic                tmo_hit_c;

    assign byte_acc_c = rx_valid_i && rx_ready_q;
    assign req_acc_c  = req_valid_q && req_ready_i;

`ifdef DBG_BRIDGE_CMD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Inter-byte idle counter; frozen while a request is waiting downstream.
    always_comb begin
        tmo_d     = tmo_q;
        tmo_hit_c = 1'b0;
        if (byte_acc_c || req_acc_c) begin
            tmo_d = '0;
        end else if (busy_q && !req_valid_q) begin
            if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit_c = 1'b1;
                tmo_d     = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit_c = 1'b0;
`endif

    // Next-state and datapath decode.
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        is_wr_d = is_wr_q;
        last_d  = last_q;
        err_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (byte_acc_c) begin
                    if (rx_data_i == CMD_WR || rx_data_i == CMD_RD) begin
                        is_wr_d = (rx_data_i == CMD_WR);
                        state_d = S_LEN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            S_LEN: begin
                if (byte_acc_c) begin
                    if (rx_data_i == 8'd0) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rem_d   = rx_data_i;
                        cnt_d   = '0;
                        state_d = S_ADDR;
                    end
                end
            end

            S_ADDR: begin
                // Address arrives MSB first; bytes above ADDR_W fall off the top.
                if (byte_acc_c) begin
                    addr_d = {addr_q[ADDR_W-9:0], rx_data_i};
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(3)) begin
                        addr_d[1:0] = 2'b00;
                        if (is_wr_q) begin
                            wdata_d = '0;
                            wstrb_d = '0;
                            state_d = S_DATA;
                        end else begin
                            wdata_d = '0;
                            wstrb_d = '1;
                            last_d  = (rem_q <= LEN_W'(4));
                            state_d = S_ISSUE;
                        end
                    end
                end
            end

            S_DATA: begin
                // cnt_q doubles as the byte lane within the current word.
                if (byte_acc_c) begin
                    wdata_d[{cnt_q, 3'b000} +: 8] = rx_data_i;
                    wstrb_d[cnt_q]                = 1'b1;
                    cnt_d                         = cnt_q + CNT_W'(1);
                    rem_d                         = rem_q - LEN_W'(1);
                    if (cnt_q == CNT_W'(3) || rem_q == LEN_W'(1)) begin
                        last_d  = (rem_q == LEN_W'(1));
                        state_d = S_ISSUE;
                    end
                end
            end

            S_ISSUE: begin
                if (req_acc_c) begin
                    if (last_q) begin
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end else begin
                        addr_d = addr_q + ADDR_W'(4);
                        if (is_wr_q) begin
                            wdata_d = '0;
                            wstrb_d = '0;
                            state_d = S_DATA;
                        end else begin
                            // rem_q counts read bytes still to cover.
                            rem_d  = rem_q - LEN_W'(4);
                            last_d = (rem_q <= LEN_W'(8));
                        end
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (tmo_hit_c) begin
            state_d = S_IDLE;
            wdata_d = '0;
            wstrb_d = '0;
            cnt_d   = '0;
            err_d   = 1'b1;
        end

        rx_ready_d  = (state_d != S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        req_valid_d = (state_d == S_ISSUE);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            rem_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            last_q      <= 1'b0;
            err_q       <= 1'b0;
            rx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            req_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            last_q      <= last_d;
            err_q       <= err_d;
            rx_ready_q  <= rx_ready_d;
            busy_q      <= busy_d;
            req_valid_q <= req_valid_d;
        end
    end

    assign rx_ready_o  = rx_ready_q;
    assign req_valid_o = req_valid_q;
    assign req_write_o = is_wr_q;
    assign req_addr_o  = addr_q;
    assign req_wdata_o = wdata_q;
    assign req_wstrb_o = wstrb_q;
    assign req_last_o  = last_q;
    assign err_o       = err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_dbg_bridge_cmd_parser.sv
// Self-checking bench for dbg_bridge_cmd_parser: directed frames from the
// test plan plus randomized frames, checked against a frame-level model.
module tb_dbg_bridge_cmd_parser;

    localparam int unsigned ADDR_W = 32;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              rx_valid_i = 1'b0;
    logic [7:0]        rx_data_i = 8'h00;
    logic              rx_ready_o;
    logic              req_valid_o;
    logic              req_ready_i = 1'b0;
    logic              req_write_o;
    logic [ADDR_W-1:0] req_addr_o;
    logic [31:0]       req_wdata_o;
    logic [3:0]        req_wstrb_o;
    logic              req_last_o;
    logic              err_o;
    logic              busy_o;

    dbg_bridge_cmd_parser #(.ADDR_W(ADDR_W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .rx_valid_i  (rx_valid_i),
        .rx_data_i   (rx_data_i),
        .rx_ready_o  (rx_ready_o),
        .req_valid_o (req_valid_o),
        .req_ready_i (req_ready_i),
        .req_write_o (req_write_o),
        .req_addr_o  (req_addr_o),
        .req_wdata_o (req_wdata_o),
        .req_wstrb_o (req_wstrb_o),
        .req_last_o  (req_last_o),
        .err_o       (err_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        last;
    } req_t;

    req_t expq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame-level model: queues the expected beats, returns expected err pulses.
    function automatic int model(input byte unsigned fr[$]);
        int unsigned len, nbeats;
        logic [31:0] base;
        req_t r;
        if (fr.size() == 0) return 0;
        if (fr[0] != 8'h10 && fr[0] != 8'h11) return 1;
        if (fr.size() < 2) return 0;
        if (fr[1] == 0) return 1;
        if (fr.size() < 6) return 0;
        len    = fr[1];
        base   = {fr[2], fr[3], fr[4], fr[5]} & 32'hFFFF_FFFC;
        nbeats = (len + 3) / 4;
        for (int unsigned b = 0; b < nbeats; b++) begin
            r.wr    = (fr[0] == 8'h10);
            r.addr  = base + 32'(4 * b);
            r.last  = (b == nbeats - 1);
            r.wdata = 32'h0;
            r.strb  = r.wr ? 4'h0 : 4'hF;
            if (r.wr) begin
                for (int unsigned j = 0; j < 4; j++) begin
                    if (4 * b + j < len) begin
                        r.wdata = r.wdata | (32'(fr[6 + 4 * b + j]) << (8 * j));
                        r.strb[j] = 1'b1;
                    end
                end
            end
            expq.push_back(r);
        end
        return 0;
    endfunction

    // Streams one frame, checks every accepted request, latency and err pulses.
    task automatic run_frame(input byte unsigned fr[$], input int stall,
                             input int gap_pct, input int rdy_pct);
        int experr, errs, idx, cyc, tail, stall_left, len;
        bit expv, exprx, expnext, snap, wr, full;
        req_t s, e;
        experr = model(fr);
        errs = 0; idx = 0; cyc = 0; tail = 0; stall_left = stall;
        expv = 0; exprx = 0; expnext = 0; snap = 0;
        full = (fr.size() >= 6);
        wr   = (fr.size() > 0) && (fr[0] == 8'h10);
        len  = (fr.size() > 1) ? int'(fr[1]) : 0;
        while (cyc < 3000) begin
            if (err_o) errs++;
            if (expv)    chk("first_beat_latency", req_valid_o, 1'b1);
            if (exprx)   chk("b2b_rx_ready", rx_ready_o, 1'b1);
            if (expnext) chk("b2b_next_read_beat", req_valid_o, 1'b1);
            expv = 0; exprx = 0; expnext = 0;
            if (req_valid_o) chk("rx_ready_low_in_issue", rx_ready_o, 1'b0);

            if (idx < fr.size() && $urandom_range(99) >= gap_pct) begin
                rx_valid_i = 1'b1;
                rx_data_i  = fr[idx];
            end else begin
                rx_valid_i = 1'b0;
                rx_data_i  = 8'($urandom);
            end

            if (req_valid_o && stall > 0 && !snap) begin
                snap = 1; s.wr = req_write_o; s.addr = req_addr_o;
                s.wdata = req_wdata_o; s.strb = req_wstrb_o; s.last = req_last_o;
            end
            if (snap && stall_left > 0) begin
                req_ready_i = 1'b0;
                chk("stall_valid", req_valid_o, 1'b1);
                chk("stall_addr", req_addr_o, s.addr);
                chk("stall_wdata", req_wdata_o, s.wdata);
                chk("stall_strb", req_wstrb_o, s.strb);
                chk("stall_last", req_last_o, s.last);
                stall_left--;
            end else begin
                req_ready_i = ($urandom_range(99) < rdy_pct);
            end

            if (req_valid_o && req_ready_i) begin
                if (expq.size() == 0) begin
                    chk("unexpected_request", 1'b1, 1'b0);
                end else begin
                    e = expq.pop_front();
                    chk("req_write", req_write_o, e.wr);
                    chk("req_addr", req_addr_o, e.addr);
                    chk("req_wdata", req_wdata_o, e.wdata);
                    chk("req_wstrb", req_wstrb_o, e.strb);
                    chk("req_last", req_last_o, e.last);
                    if (!e.last) begin
                        if (e.wr) exprx = 1; else expnext = 1;
                    end
                end
            end

            if (rx_valid_i && rx_ready_o) begin
                if (full && ((!wr && idx == 5) ||
                    (wr && idx >= 6 && (((idx - 6) % 4 == 3) || idx == len + 5))))
                    expv = 1;
                idx++;
            end

            if (idx == fr.size() && expq.size() == 0 && !req_valid_o) tail++;
            if (tail >= 3 && !expv && !exprx && !expnext) break;
            @(posedge clk_i); #1;
            cyc++;
        end
        rx_valid_i  = 1'b0;
        req_ready_i = 1'b0;
        if (cyc >= 3000) chk("frame_cycle_budget", 1'b0, 1'b1);
        chk("err_pulses", 64'(errs), 64'(experr));
        chk("beats_outstanding", 64'(expq.size()), 64'd0);
        expq.delete();
    endtask

    function automatic void rand_frame(output byte unsigned fr[$]);
        int unsigned len, kind;
        logic [31:0] a;
        fr.delete();
        kind = $urandom_range(9);
        if (kind == 0) begin
            fr.push_back(8'h55 ^ 8'($urandom_range(1, 255)));
            if (fr[0] == 8'h10 || fr[0] == 8'h11) fr[0] = 8'hFF;
            return;
        end
        if (kind == 1) begin
            fr.push_back($urandom_range(1) ? 8'h10 : 8'h11);
            fr.push_back(8'h00);
            return;
        end
        len = $urandom_range(1, 24);
        a   = (kind == 2) ? (32'hFFFF_FFF0 | 32'($urandom_range(15))) : 32'($urandom);
        fr.push_back((kind % 2 == 0) ? 8'h10 : 8'h11);
        fr.push_back(8'(len));
        fr.push_back(a[31:24]); fr.push_back(a[23:16]);
        fr.push_back(a[15:8]);  fr.push_back(a[7:0]);
        if (fr[0] == 8'h10)
            for (int unsigned i = 0; i < len; i++) fr.push_back(8'($urandom));
    endfunction

    initial begin
        byte unsigned fr[$];

        // Reset state while rst_i is low.
        #2;
        chk("rst_rx_ready", rx_ready_o, 1'b0);
        chk("rst_req_valid", req_valid_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_addr", req_addr_o, 32'h0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("idle_rx_ready", rx_ready_o, 1'b1);
        chk("idle_busy", busy_o, 1'b0);

        // Two-beat write.
        fr = {8'h10, 8'h08, 8'h00, 8'h00, 8'h10, 8'h00,
              8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_frame(fr, 0, 0, 100);
        // Same write with downstream stalled 20 cycles on the first beat.
        run_frame(fr, 20, 0, 100);

        // Reads of 4 and 9 bytes.
        fr = {8'h11, 8'h04, 8'h00, 8'h00, 8'h10, 8'h00};
        run_frame(fr, 0, 0, 100);
        fr = {8'h11, 8'h09, 8'h00, 8'h00, 8'h10, 8'h00};
        run_frame(fr, 0, 0, 100);

        // Unaligned base, partial final word.
        fr = {8'h10, 8'h05, 8'h00, 8'h00, 8'h20, 8'h03,
              8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        run_frame(fr, 0, 0, 100);

        // Bad command, LEN=0, then a good read.
        fr = {8'h55};
        run_frame(fr, 0, 0, 100);
        fr = {8'h10, 8'h00};
        run_frame(fr, 0, 0, 100);
        fr = {8'h11, 8'h04, 8'h00, 8'h00, 8'h30, 8'h00};
        run_frame(fr, 0, 0, 100);

        // Asynchronous reset after three address bytes.
        fr = {8'h10, 8'h04, 8'h00, 8'h00, 8'h10};
        run_frame(fr, 0, 0, 100);
        chk("midframe_busy", busy_o, 1'b1);
        #2 rst_i = 1'b0;
        #1;
        chk("async_rst_busy", busy_o, 1'b0);
        chk("async_rst_valid", req_valid_o, 1'b0);
        chk("async_rst_rx_ready", rx_ready_o, 1'b0);
        @(posedge clk_i); #2 rst_i = 1'b1;
        @(posedge clk_i); #1;
        chk("post_rst_idle_ready", rx_ready_o, 1'b1);
        fr = {8'h10, 8'h04, 8'h00, 8'h00, 8'h10, 8'h04,
              8'hDE, 8'hAD, 8'hBE, 8'hEF};
        run_frame(fr, 0, 0, 100);

        // Randomized frames with byte gaps and downstream backpressure.
        for (int n = 0; n < 60; n++) begin
            rand_frame(fr);
            run_frame(fr, 0, $urandom_range(40), $urandom_range(30, 100));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
